ldpc_frame_sequencer: RTL and testbench
=======================================

// Module: ldpc_frame_sequencer
// PURPOSE
//  Autonomous frame-loop controller for the LDPC encoder/decoder pair. Per frame: drives a message
//  into the encoder, captures the codeword, applies an error mask to build q0_0/q0_1, pulses
//  start_dec, awaits decoder completion and scores the result. Sits between LDPC_CSR and the
//  encoder/decoder wrappers; replaces firmware-driven single-shot operation for batch BER runs.
// PARAMETERS
//  MM       'h0a8  parity bits (rows of H)
//  NN       'h0d0  codeword bits
//  CNT_W    16     frame/score counter width
//  TO_W     16     timeout counter width
//  ENC_LAT  2      min cycles after message update before i_enc_valid is trusted
// PORTS
//  i_clk          in   1        clock (wb_clk_i domain)
//  i_rst_n        in   1        asynchronous active-low reset
//  i_start        in   1        start batch (1-cycle pulse; ignored while o_busy)
//  i_abort        in   1        abort batch (level, sampled every cycle)
//  i_frame_cnt    in   CNT_W    frames to run (latched at start)
//  i_timeout      in   TO_W     per-phase cycle limit; 0 = no timeout (latched at start)
//  i_msg          in   NN-MM    message payload (latched at start)
//  i_err_mask     in   NN       error pattern XORed into codeword (latched at start)
//  o_enc_msg      out  NN-MM    to encoder y_nr_in_port
//  i_enc_cword    in   NN       encoder y_nr_enc
//  i_enc_valid    in   1        encoder valid_cword_enc
//  o_q0_0/o_q0_1  out  NN       decoder channel inputs
//  o_start_dec    out  1        1-cycle decoder start pulse
//  i_dec_ended    in   1        decoder converged_loops_ended
//  i_dec_final    in   NN       decoder final_y_nr_dec
//  o_busy         out  1        batch in progress
//  o_done         out  1        1-cycle pulse at batch end (normal or abort)
//  o_aborted      out  1        sticky: last batch aborted; cleared on next accepted start
//  o_frame_idx    out  CNT_W    frames completed in current/last batch
//  o_pass_cnt/o_fail_cnt/o_to_cnt  out  CNT_W  score counters (saturating)
//  o_state        out  3        FSM state encoding, for CSR readback
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, latched config 0.
//  FSM: IDLE -> ENC -> LOAD -> DEC -> CHECK -> (ENC | IDLE).
//   IDLE: on i_start & ~o_busy latch config, clear counters/frame_idx/o_aborted; frame_cnt==0 ->
//         o_done next cycle, stay IDLE; else -> ENC, o_busy=1.
//   ENC:  o_enc_msg held; wait >=ENC_LAT cycles then i_enc_valid=1 -> LOAD.
//   LOAD: register cword; o_q0_1 = cword ^ err_mask; o_q0_0 = ~o_q0_1; hold until next LOAD -> DEC.
//   DEC:  o_start_dec=1 on first DEC cycle only; wait i_dec_ended; ended sampled from 2nd DEC cycle.
//   CHECK: pass = (i_dec_final == stored cword); pass_cnt or fail_cnt +1; frame_idx +1;
//          frame_idx+1 == frame_cnt -> IDLE with o_done, o_busy=0; else -> ENC.
//  Timeout: phase counter resets on entry to ENC/DEC; reaching i_timeout (nonzero) -> to_cnt +1,
//   frame counted as neither pass nor fail, frame_idx +1, proceed as from CHECK.
//  Abort: any non-IDLE state -> IDLE next cycle, o_done pulse, o_aborted=1, counters frozen.
//   Abort wins over simultaneous timeout/ended/valid. Abort in IDLE ignored.
//  Counters saturate at all-ones; no wrap. frame_idx compared as CNT_W unsigned.
//  Latency per frame min: ENC_LAT+1 (ENC) +1 (LOAD) +decoder time +1 (CHECK).
// CONFIGURATION
//  LDPC_SEQ_LFSR_MSG_EN: defined -> 32-bit Galois LFSR (poly 0x80200003, seed = i_msg[31:0], 0
//   replaced by 1) advances once per frame entering ENC; o_enc_msg = LFSR bits replicated to NN-MM.
//   Undefined -> o_enc_msg = latched i_msg for every frame; no LFSR logic synthesized.
// STRUCTURE
//  Package ldpc_seq_pkg: state enum (IDLE=0,ENC=1,LOAD=2,DEC=3,CHECK=4), LFSR poly/default seed.
//  Sub-module ldpc_seq_lfsr (present only under LDPC_SEQ_LFSR_MSG_EN); counters inline.
// TESTING
//  1 frame_cnt=3, mask=0, ideal decoder model -> 3 o_start_dec pulses, pass_cnt=3, o_done once.
//  2 frame_cnt=2, mask=1 bit, decoder returns corrupted word -> fail_cnt=2, pass_cnt=0.
//  3 timeout=10, decoder never ends -> to_cnt increments after 10 DEC cycles, batch completes.
//  4 i_abort in DEC of frame 2 -> IDLE next cycle, o_done, o_aborted=1, frame_idx=1.
//  5 frame_cnt=0 -> o_done 1 cycle after start, o_busy never 1; start while busy ignored.
//  6 i_rst_n low mid-DEC -> all outputs 0 immediately; LFSR_EN build: 2 frames give distinct msgs.

Source files
------------

// File: rtl/ldpc_seq_pkg.sv
// Shared definitions for the LDPC frame sequencer.
//   seq_state_e : FSM encoding, also exported on o_state for CSR readback
//   LFSR_POLY   : Galois feedback taps for the optional message generator
//   LFSR_SEED   : substitute seed used when the supplied seed is zero
//   lfsr_next() : one right-shift Galois step
package ldpc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENC   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DEC   = 3'd3,
    ST_CHECK = 3'd4
  } seq_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ldpc_seq_lfsr.sv
// Per-frame message generator (used only when LDPC_SEQ_LFSR_MSG_EN is defined).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload from seed (zero seed replaced by LFSR_SEED), stepping once
//   step       : advance one Galois step
//   seed       : 32-bit seed
//   value      : current LFSR state
module ldpc_seq_lfsr
  import ldpc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  // The load step also advances, so the first frame already sees a stepped value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= lfsr_next((seed == '0) ? LFSR_SEED : seed);
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/ldpc_frame_sequencer.sv
// Autonomous frame-loop controller for the LDPC encoder/decoder pair.
// Per frame: present message to encoder, capture codeword, apply error mask to
// build decoder channel inputs, pulse decoder start, await completion, score.
// Build option: LDPC_SEQ_LFSR_MSG_EN -> per-frame LFSR message instead of the
// latched i_msg.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_abort          batch start pulse, abort level
//   i_frame_cnt, i_timeout    frames to run, per-phase cycle limit (0 = none)
//   i_msg, i_err_mask         message payload, codeword error pattern
//   o_enc_msg                 encoder message input
//   i_enc_cword, i_enc_valid  encoder codeword and valid
//   o_q0_0, o_q0_1            decoder channel inputs
//   o_start_dec               decoder start pulse
//   i_dec_ended, i_dec_final  decoder completion and decoded word
//   o_busy, o_done, o_aborted batch status
//   o_frame_idx, o_pass_cnt, o_fail_cnt, o_to_cnt  saturating counters
//   o_state                   FSM state for readback
module ldpc_frame_sequencer
  import ldpc_seq_pkg::*;
#(
  parameter int unsigned MM      = 'h0a8,
  parameter int unsigned NN      = 'h0d0,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TO_W    = 16,
  parameter int unsigned ENC_LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_frame_cnt,
  input  logic [TO_W-1:0]  i_timeout,
  input  logic [NN-MM-1:0] i_msg,
  input  logic [NN-1:0]    i_err_mask,
  output logic [NN-MM-1:0] o_enc_msg,
  input  logic [NN-1:0]    i_enc_cword,
  input  logic             i_enc_valid,
  output logic [NN-1:0]    o_q0_0,
  output logic [NN-1:0]    o_q0_1,
  output logic             o_start_dec,
  input  logic             i_dec_ended,
  input  logic [NN-1:0]    i_dec_final,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_frame_idx,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic [CNT_W-1:0] o_to_cnt,
  output logic [2:0]       o_state
);

  localparam int unsigned MW = NN - MM;

  seq_state_e       state, state_nx;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [TO_W-1:0]  timeout_q;
  logic [TO_W-1:0]  phase_cnt;
  logic [NN-1:0]    mask_q;
  logic [NN-1:0]    cword_q;
  logic             accept, enc_fire, chk_fire, to_fire, aborting;
  logic             to_hit, last, enter_enc, phase_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign o_state   = state;
  assign phase_clr = enter_enc || (state == ST_LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Abort overrides every other event; a timed-out frame ends exactly like a
  // CHECK, so both share the frame-end path at the bottom.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    enc_fire = 1'b0;
    chk_fire = 1'b0;
    to_fire  = 1'b0;
    aborting = (state != ST_IDLE) && i_abort;
    to_hit   = (timeout_q != '0) && (phase_cnt == timeout_q - TO_W'(1));
    last     = (o_frame_idx + CNT_W'(1)) == frame_cnt_q;
    if (aborting) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            accept = 1'b1;
            if (i_frame_cnt != '0) state_nx = ST_ENC;
          end
        end
        ST_ENC: begin
          if ((phase_cnt >= TO_W'(ENC_LAT)) && i_enc_valid) begin
            enc_fire = 1'b1;
            state_nx = ST_LOAD;
          end else if (to_hit) begin
            to_fire = 1'b1;
          end
        end
        ST_LOAD: state_nx = ST_DEC;
        ST_DEC: begin
          // ended is a level from the previous frame during the first DEC cycle
          if ((phase_cnt != '0) && i_dec_ended) state_nx = ST_CHECK;
          else if (to_hit)                      to_fire  = 1'b1;
        end
        ST_CHECK: chk_fire = 1'b1;
        default:  state_nx = ST_IDLE;
      endcase
      if (to_fire || chk_fire) state_nx = last ? ST_IDLE : ST_ENC;
    end
    enter_enc = (accept && (i_frame_cnt != '0)) || ((to_fire || chk_fire) && !last);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_cnt <= '0;
    end else if (phase_clr) begin
      phase_cnt <= '0;
    end else if (phase_cnt != '1) begin
      phase_cnt <= phase_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      timeout_q   <= '0;
      mask_q      <= '0;
      cword_q     <= '0;
      o_q0_0      <= '0;
      o_q0_1      <= '0;
      o_start_dec <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_aborted   <= 1'b0;
      o_frame_idx <= '0;
      o_pass_cnt  <= '0;
      o_fail_cnt  <= '0;
      o_to_cnt    <= '0;
    end else begin
      o_done      <= (accept && (i_frame_cnt == '0)) || aborting ||
                     ((to_fire || chk_fire) && last);
      o_busy      <= (state_nx != ST_IDLE);
      o_start_dec <= (state == ST_LOAD) && !i_abort;
      if (accept) begin
        frame_cnt_q <= i_frame_cnt;
        timeout_q   <= i_timeout;
        mask_q      <= i_err_mask;
        o_aborted   <= 1'b0;
        o_frame_idx <= '0;
        o_pass_cnt  <= '0;
        o_fail_cnt  <= '0;
        o_to_cnt    <= '0;
      end
      if (aborting) o_aborted <= 1'b1;
      if (enc_fire) cword_q <= i_enc_cword;
      if ((state == ST_LOAD) && !i_abort) begin
        o_q0_1 <= cword_q ^ mask_q;
        o_q0_0 <= ~(cword_q ^ mask_q);
      end
      if (chk_fire) begin
        if (i_dec_final == cword_q) o_pass_cnt <= sat_inc(o_pass_cnt);
        else                        o_fail_cnt <= sat_inc(o_fail_cnt);
      end
      if (to_fire)              o_to_cnt    <= sat_inc(o_to_cnt);
      if (to_fire || chk_fire)  o_frame_idx <= sat_inc(o_frame_idx);
    end
  end

`ifdef LDPC_SEQ_LFSR_MSG_EN
  logic [31:0] lfsr_val;

  ldpc_seq_lfsr u_lfsr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (accept && (i_frame_cnt != '0)),
    .step  (enter_enc && !accept),
    .seed  (i_msg[31:0]),
    .value (lfsr_val)
  );

  always_comb begin
    o_enc_msg = '0;
    for (int unsigned i = 0; i < MW; i++) o_enc_msg[i] = lfsr_val[i % 32];
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_enc_msg <= '0;
    else if (accept) o_enc_msg <= i_msg;
  end
`endif

endmodule

// File: tb/tb_ldpc_frame_sequencer.sv
// Self-checking bench for ldpc_frame_sequencer: environment models for the
// encoder and decoder, a frame-level reference model stepped every clock, a
// per-cycle compare process, and directed plus randomized batches.
module tb_ldpc_frame_sequencer;

  localparam int unsigned MM      = 168;
  localparam int unsigned NN      = 208;
  localparam int unsigned MW      = NN - MM;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TO_W    = 16;
  localparam int unsigned ENC_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start, i_abort;
  logic [CNT_W-1:0] i_frame_cnt;
  logic [TO_W-1:0]  i_timeout;
  logic [MW-1:0]    i_msg;
  logic [NN-1:0]    i_err_mask;
  logic [MW-1:0]    o_enc_msg;
  logic [NN-1:0]    i_enc_cword;
  logic             i_enc_valid;
  logic [NN-1:0]    o_q0_0, o_q0_1;
  logic             o_start_dec;
  logic             i_dec_ended;
  logic [NN-1:0]    i_dec_final;
  logic             o_busy, o_done, o_aborted;
  logic [CNT_W-1:0] o_frame_idx, o_pass_cnt, o_fail_cnt, o_to_cnt;
  logic [2:0]       o_state;

  ldpc_frame_sequencer #(
    .MM(MM), .NN(NN), .CNT_W(CNT_W), .TO_W(TO_W), .ENC_LAT(ENC_LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_frame_cnt(i_frame_cnt), .i_timeout(i_timeout), .i_msg(i_msg),
    .i_err_mask(i_err_mask), .o_enc_msg(o_enc_msg), .i_enc_cword(i_enc_cword),
    .i_enc_valid(i_enc_valid), .o_q0_0(o_q0_0), .o_q0_1(o_q0_1),
    .o_start_dec(o_start_dec), .i_dec_ended(i_dec_ended), .i_dec_final(i_dec_final),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
    .o_frame_idx(o_frame_idx), .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt),
    .o_to_cnt(o_to_cnt), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  bit chk_en = 0;
  int sd_cnt = 0, done_cnt = 0, busy_cnt = 0, dec_cyc = 0;
  logic [MW-1:0] msgq[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [NN-1:0] rand_nn();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r[NN-1:0];
  endfunction

  // ---------------- environment: encoder and decoder ----------------
  int            dec_mode = 0;   // 0 ideal, 1 returns corrupted word, 2 never ends
  bit            enc_rand = 1;
  logic [NN-1:0] cur_mask = '0;
  int            dec_wait = 0;

  initial begin
    i_enc_valid = 0; i_enc_cword = '0; i_dec_ended = 0; i_dec_final = '0;
    forever begin
      @(negedge clk);
      i_enc_valid = enc_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_enc_cword = rand_nn();
      if (o_start_dec) begin
        dec_wait    = $urandom_range(1, 4);
        // random early ended level in the first DEC cycle must be ignored
        i_dec_ended = (dec_mode != 2) && ($urandom_range(0, 1) == 1);
        case (dec_mode)
          0:       i_dec_final = o_q0_1 ^ cur_mask;
          1:       i_dec_final = o_q0_1;
          default: i_dec_final = rand_nn();
        endcase
      end else begin
        if (dec_wait > 0) dec_wait--;
        i_dec_ended = (dec_mode != 2) && (dec_wait == 0);
      end
    end
  end

  // ---------------- reference model ----------------
  // m_phase: 0 idle, 1 encode, 2 load, 3 decode, 4 check; m_k cycles spent in phase
  int            m_phase, m_k;
  logic          m_busy, m_done, m_ab, m_sd;
  int            m_fc, m_to_lim, m_idx, m_pass, m_fail, m_tocnt;
  logic [NN-1:0] m_mask, m_cw, m_q1, m_q0;
  logic [MW-1:0] m_msg;
  logic [31:0]   m_lfsr;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_done = 0; m_ab = 0; m_sd = 0;
    m_fc = 0; m_to_lim = 0; m_idx = 0; m_pass = 0; m_fail = 0; m_tocnt = 0;
    m_mask = '0; m_cw = '0; m_q1 = '0; m_q0 = '0; m_msg = '0; m_lfsr = '0;
  endtask

  task automatic begin_frame();
    m_phase = 1; m_k = 0;
`ifdef LDPC_SEQ_LFSR_MSG_EN
    m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
    for (int i = 0; i < MW; i++) m_msg[i] = m_lfsr[i % 32];
`endif
  endtask

  task automatic model_step();
    bit fin, tout;
    m_done = 0; m_sd = 0; fin = 0;
    if (m_phase == 0) begin
      if (i_start) begin
        m_fc = int'(i_frame_cnt); m_to_lim = int'(i_timeout); m_mask = i_err_mask;
        m_idx = 0; m_pass = 0; m_fail = 0; m_tocnt = 0; m_ab = 0;
`ifndef LDPC_SEQ_LFSR_MSG_EN
        m_msg = i_msg;
`endif
        if (m_fc == 0) m_done = 1;
        else begin
`ifdef LDPC_SEQ_LFSR_MSG_EN
          m_lfsr = (i_msg[31:0] == 32'h0) ? 32'h1 : i_msg[31:0];
`endif
          begin_frame();
        end
      end
    end else if (i_abort) begin
      m_phase = 0; m_done = 1; m_ab = 1;
    end else begin
      tout = (m_to_lim != 0) && (m_k + 1 == m_to_lim);
      case (m_phase)
        1: if (m_k >= ENC_LAT && i_enc_valid) begin m_cw = i_enc_cword; m_phase = 2; end
           else if (tout) begin m_tocnt = sat(m_tocnt + 1); fin = 1; end
           else m_k++;
        2: begin m_q1 = m_cw ^ m_mask; m_q0 = ~m_q1; m_sd = 1; m_phase = 3; m_k = 0; end
        3: if (m_k >= 1 && i_dec_ended) m_phase = 4;
           else if (tout) begin m_tocnt = sat(m_tocnt + 1); fin = 1; end
           else m_k++;
        default: begin
          if (i_dec_final == m_cw) m_pass = sat(m_pass + 1);
          else                     m_fail = sat(m_fail + 1);
          fin = 1;
        end
      endcase
      if (fin) begin
        m_idx = sat(m_idx + 1);
        if (m_idx == m_fc) begin m_phase = 0; m_done = 1; end
        else begin_frame();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy",      o_busy,      m_phase != 0);
      chk("done",      o_done,      m_done);
      chk("aborted",   o_aborted,   m_ab);
      chk("state",     o_state,     m_phase[2:0]);
      chk("start_dec", o_start_dec, m_sd);
      chk("frame_idx", o_frame_idx, m_idx[CNT_W-1:0]);
      chk("pass_cnt",  o_pass_cnt,  m_pass[CNT_W-1:0]);
      chk("fail_cnt",  o_fail_cnt,  m_fail[CNT_W-1:0]);
      chk("to_cnt",    o_to_cnt,    m_tocnt[CNT_W-1:0]);
      chk("q0_1",      o_q0_1,      m_q1);
      chk("q0_0",      o_q0_0,      m_q0);
      chk("enc_msg",   o_enc_msg,   m_msg);
      if (o_start_dec) begin sd_cnt++; msgq.push_back(o_enc_msg); end
      if (o_done) done_cnt++;
      if (o_busy) busy_cnt++;
      if (o_state == 3'd3) dec_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_batch(input int fc, input int to, input logic [NN-1:0] mask,
                           input int mode, input bit erand, input int abort_at,
                           input int spur_at, input logic [MW-1:0] msg);
    bit got = 0;
    dec_mode = mode; enc_rand = erand; cur_mask = mask;
    i_frame_cnt = CNT_W'(fc); i_timeout = TO_W'(to); i_err_mask = mask; i_msg = msg;
    i_start = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_start = 0; i_abort = 0;
      if (o_done) begin got = 1; break; end
      if (c == abort_at) i_abort = 1;
      if (c == spur_at && o_busy) begin
        i_start = 1; i_frame_cnt = CNT_W'($urandom_range(1, 9));
        i_timeout = TO_W'($urandom_range(0, 5)); i_err_mask = rand_nn();
        i_msg = MW'({$urandom, $urandom});
      end
    end
    chk("batch_completes", got, 1'b1);
    i_start = 0; i_abort = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    int b_sd, b_done, b_busy, b_dec;
    bit got;
    i_start = 0; i_abort = 0; i_frame_cnt = '0; i_timeout = '0; i_msg = '0; i_err_mask = '0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);           chk("rst_done", o_done, 0);
    chk("rst_state", o_state, 0);         chk("rst_pass", o_pass_cnt, 0);
    chk("rst_q0_0", o_q0_0, 0);           chk("rst_enc_msg", o_enc_msg, 0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);

    // 1: three clean frames with an ideal decoder
    msgq.delete();
    b_sd = sd_cnt; b_done = done_cnt;
    run_batch(3, 0, '0, 0, 1, -1, -1, 40'h12_3456_789A);
    chk("t1_pass_cnt", o_pass_cnt, 16'd3);
    chk("t1_start_dec_pulses", sd_cnt - b_sd, 3);
    chk("t1_done_pulses", done_cnt - b_done, 1);
`ifdef LDPC_SEQ_LFSR_MSG_EN
    chk("t6_lfsr_distinct", (msgq.size() >= 2) && (msgq[0] != msgq[1]), 1'b1);
`else
    chk("t1_msg_held", (msgq.size() >= 2) ? msgq[1] : '0, 40'h12_3456_789A);
`endif

    // 2: single-bit error, decoder hands back the corrupted word
    run_batch(2, 0, NN'(1) << 5, 1, 1, -1, -1, 40'hA5);
    chk("t2_fail_cnt", o_fail_cnt, 16'd2);
    chk("t2_pass_cnt", o_pass_cnt, 16'd0);

    // 3: decoder never ends, 10-cycle timeout
    b_dec = dec_cyc;
    run_batch(2, 10, '0, 2, 0, -1, -1, 40'h3C);
    chk("t3_to_cnt", o_to_cnt, 16'd2);
    chk("t3_dec_cycles", dec_cyc - b_dec, 20);
    chk("t3_frame_idx", o_frame_idx, 16'd2);

    // 4: abort in DEC of frame 2
    dec_mode = 0; enc_rand = 1; cur_mask = '0;
    i_frame_cnt = 16'd4; i_timeout = '0; i_err_mask = '0; i_msg = 40'h77;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    got = 0;
    for (int c = 0, n = 0; c < 2000; c++) begin
      if (o_start_dec) begin n++; if (n == 2) begin got = 1; break; end end
      @(negedge clk);
    end
    chk("t4_reach_frame2_dec", got, 1'b1);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
    chk("t4_done", o_done, 1'b1);
    chk("t4_aborted", o_aborted, 1'b1);
    chk("t4_frame_idx", o_frame_idx, 16'd1);
    chk("t4_busy", o_busy, 1'b0);
    i_abort = 1;
    repeat (3) @(negedge clk);
    i_abort = 0;
    chk("t4_idle_abort_ignored", {o_aborted, o_busy, o_state}, {1'b1, 1'b0, 3'd0});

    // 5: zero-frame batch, then a start while busy
    b_busy = busy_cnt; b_done = done_cnt;
    run_batch(0, 0, '0, 0, 1, -1, -1, 40'h11);
    chk("t5_busy_never", busy_cnt - b_busy, 0);
    chk("t5_done_once", done_cnt - b_done, 1);
    run_batch(2, 0, '0, 0, 1, -1, 3, 40'h22);
    chk("t5_busy_start_ignored", o_frame_idx, 16'd2);

    // 6: reset asserted mid-DEC
    dec_mode = 2; enc_rand = 0;
    i_frame_cnt = 16'd3; i_timeout = 16'd50; i_msg = 40'h99; i_start = 1;
    @(negedge clk);
    i_start = 0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (o_state == 3'd3) begin got = 1; break; end
      @(negedge clk);
    end
    chk("t6_reach_dec", got, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_busy", o_busy, 0);       chk("t6_rst_state", o_state, 0);
    chk("t6_rst_q0_1", o_q0_1, 0);       chk("t6_rst_enc_msg", o_enc_msg, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // randomized batches
    for (int b = 0; b < 16; b++) begin
      int fc, to, mode, ab;
      fc   = $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      to   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 14);
      if (mode == 2 && to == 0) to = $urandom_range(3, 14);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_batch(fc, to, ($urandom_range(0, 1) == 1) ? rand_nn() : '0, mode, 1, ab,
                $urandom_range(0, 30), MW'({$urandom, $urandom}));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
